// File: rtl/buffer_pkg.sv
// Shared definitions for the ping-pong buffer: access modes and byte-lane helpers
// used by both the bank storage and the top-level ownership logic.
package buffer_pkg;

   localparam logic MODE_BYTE = 1'b0;
   localparam logic MODE_WORD = 1'b1;

   // Widest word the helpers accept; banks narrow arguments and results to their own width.
   localparam int MAX_WORD_BYTES = 64;
   localparam int MAX_W          = 8 * MAX_WORD_BYTES;

   function automatic logic lane_hit(input logic mode, input int unsigned lane_sel,
                                     input int unsigned lane);
      return (mode == MODE_WORD) || (lane == lane_sel);
   endfunction

   function automatic logic [7:0] byte_extract(input logic [MAX_W-1:0] word,
                                               input int unsigned lane);
      return word[lane*8 +: 8];
   endfunction

endpackage

// File: rtl/buffer_bank.sv
// One bank of byte/word-addressable storage with lane-masked writes and a
// registered read port that holds its value between reads.
module buffer_bank
   import buffer_pkg::*;
#(
   parameter int WordBytes = 8,
   parameter int ByteAddrW = 8,
   parameter int WordAddrW = 5,
   localparam int W        = 8 * WordBytes,
   localparam int LaneW    = ByteAddrW - WordAddrW,
   localparam int Words    = 2 ** WordAddrW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic                 wr_mode,
   input  logic [ByteAddrW-1:0] wr_addr,
   input  logic [W-1:0]         wr_data,
   input  logic                 rd_en,
   input  logic                 rd_mode,
   input  logic [ByteAddrW-1:0] rd_addr,
   output logic [W-1:0]         rd_data
);

   logic [W-1:0]         mem [Words];
   logic [WordAddrW-1:0] wr_idx;
   logic [WordAddrW-1:0] rd_idx;
   logic [LaneW-1:0]     wr_lane;
   logic [LaneW-1:0]     rd_lane;
   logic [W-1:0]         wr_word;
   logic [W-1:0]         rd_word;

   assign wr_lane = wr_addr[LaneW-1:0];
   assign rd_lane = rd_addr[LaneW-1:0];
   assign wr_idx  = (wr_mode == MODE_WORD) ? wr_addr[WordAddrW-1:0] : wr_addr[ByteAddrW-1:LaneW];
   assign rd_idx  = (rd_mode == MODE_WORD) ? rd_addr[WordAddrW-1:0] : rd_addr[ByteAddrW-1:LaneW];

   // Byte writes replicate the byte to every lane; the lane mask picks the one that lands.
   assign wr_word = (wr_mode == MODE_WORD) ? wr_data : {WordBytes{wr_data[7:0]}};
   assign rd_word = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < WordBytes; i++) begin
            if (lane_hit(wr_mode, 32'(wr_lane), i))
               mem[wr_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= (rd_mode == MODE_WORD) ? rd_word
                                           : W'(byte_extract(MAX_W'(rd_word), 32'(rd_lane)));
   end

endmodule

// File: rtl/pingpong_buffer.sv
// Double-banked producer/consumer buffer: ownership and full-flag handshake
// logic, with write and read ports steered to opposite banks.
module pingpong_buffer
   import buffer_pkg::*;
#(
   parameter int WordBytes  = 8,
   parameter int BuffDepth  = 256,
   localparam int ByteAddrW = $clog2(BuffDepth),
   localparam int WordAddrW = $clog2(BuffDepth / WordBytes),
   localparam int W         = 8 * WordBytes
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic                 wr_mode,
   input  logic [ByteAddrW-1:0] wr_addr,
   input  logic [W-1:0]         wr_data,
   input  logic                 wr_done,
   output logic                 wr_ready,
   input  logic                 rd_en,
   input  logic                 rd_mode,
   input  logic [ByteAddrW-1:0] rd_addr,
   input  logic                 rd_done,
   output logic                 rd_ready,
   output logic [W-1:0]         rd_data,
   output logic                 rd_valid,
   output logic                 wr_bank,
   output logic [1:0]           bank_full
);

   logic         rd_bank;
   logic         wr_acc;
   logic         rd_acc;
   logic [1:0]   full_nxt;
   logic         bank_nxt;
   logic         rd_sel_p0;
   logic [W-1:0] bank_rd [2];

   assign rd_bank  = ~wr_bank;
   assign wr_ready = ~bank_full[wr_bank];
   assign rd_ready = bank_full[rd_bank];
   assign wr_acc   = wr_en & wr_ready;
   assign rd_acc   = rd_en & rd_ready;

   // Swap is decided on the post-handshake flags so a release and a completion
   // in the same cycle hand the fresh bank over at once.
   always_comb begin
      full_nxt = bank_full;
      bank_nxt = wr_bank;
      if (wr_done && wr_ready) full_nxt[wr_bank] = 1'b1;
      if (rd_done && rd_ready) full_nxt[rd_bank] = 1'b0;
      if (full_nxt[wr_bank] && !full_nxt[rd_bank]) bank_nxt = rd_bank;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank   <= 1'b0;
         bank_full <= 2'b00;
         rd_valid  <= 1'b0;
         rd_sel_p0 <= 1'b0;
      end else begin
         wr_bank   <= bank_nxt;
         bank_full <= full_nxt;
         rd_valid  <= rd_acc;
         if (rd_acc) rd_sel_p0 <= rd_bank;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      buffer_bank #(
         .WordBytes (WordBytes),
         .ByteAddrW (ByteAddrW),
         .WordAddrW (WordAddrW)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (wr_acc && (wr_bank == 1'(b))),
         .wr_mode (wr_mode),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_en   (rd_acc && (rd_bank == 1'(b))),
         .rd_mode (rd_mode),
         .rd_addr (rd_addr),
         .rd_data (bank_rd[b])
      );
   end

   // Each bank's read register only moves on its own reads, so selecting the
   // last-read bank gives hold-between-reads for free.
   assign rd_data = bank_rd[rd_sel_p0];

endmodule

// File: tb/tb_pingpong_buffer.sv
// Scoreboard bench for pingpong_buffer: byte-array reference model, read
// expectations queued at issue and popped by a negedge monitor.
module tb_pingpong_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, wr_mode, wr_done, wr_ready;
   logic [7:0]  wr_addr, rd_addr;
   logic [63:0] wr_data, rd_data;
   logic        rd_en, rd_mode, rd_done, rd_ready, rd_valid, wr_bank;
   logic [1:0]  bank_full;

   always #5 clk = ~clk;

   pingpong_buffer #(.WordBytes(8), .BuffDepth(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_mode(rd_mode), .rd_addr(rd_addr), .rd_done(rd_done),
      .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_bank(wr_bank), .bank_full(bank_full)
   );

   typedef struct {
      logic [63:0] data;
      logic [63:0] mask;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  m_mem   [2][256];
   bit          m_known [2][256];
   bit          m_full  [2];
   bit          m_wb;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_flags();
      check("wr_ready", 64'(wr_ready), 64'(!m_full[m_wb]));
      check("rd_ready", 64'(rd_ready), 64'(m_full[!m_wb]));
      check("wr_bank", 64'(wr_bank), 64'(m_wb));
      check("bank_full", 64'(bank_full), 64'({m_full[1], m_full[0]}));
   endtask

   task automatic model_reset();
      m_full[0] = 0;
      m_full[1] = 0;
      m_wb      = 0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) m_known[b][a] = 0;
      exp_q.delete();
   endtask

   // Spec-level behaviour of one clock edge with the given inputs.
   task automatic model_edge(input bit we, input bit wm, input logic [7:0] wa,
                             input logic [63:0] wd, input bit wdn, input bit re,
                             input bit rm, input logic [7:0] ra, input bit rdn);
      bit   wrdy, rrdy, rb;
      int   base;
      exp_t e;
      wrdy = !m_full[m_wb];
      rrdy = m_full[!m_wb];
      rb   = !m_wb;
      if (re && rrdy) begin
         e.data = '0;
         e.mask = '0;
         if (rm) begin
            base = int'(ra[4:0]) * 8;
            for (int k = 0; k < 8; k++)
               if (m_known[rb][base+k]) begin
                  e.data[k*8 +: 8] = m_mem[rb][base+k];
                  e.mask[k*8 +: 8] = 8'hFF;
               end
         end else begin
            e.mask[63:8] = '1;
            if (m_known[rb][ra]) begin
               e.data[7:0] = m_mem[rb][ra];
               e.mask[7:0] = 8'hFF;
            end
         end
         exp_q.push_back(e);
      end
      if (we && wrdy) begin
         if (wm) begin
            base = int'(wa[4:0]) * 8;
            for (int k = 0; k < 8; k++) begin
               m_mem[m_wb][base+k]   = wd[k*8 +: 8];
               m_known[m_wb][base+k] = 1;
            end
         end else begin
            m_mem[m_wb][wa]   = wd[7:0];
            m_known[m_wb][wa] = 1;
         end
      end
      if (wdn && wrdy) m_full[m_wb] = 1;
      if (rdn && rrdy) m_full[!m_wb] = 0;
      if (m_full[m_wb] && !m_full[!m_wb]) m_wb = !m_wb;
   endtask

   // Called at posedge+1; drives inputs, advances one edge, checks flags.
   task automatic step(input bit we, input bit wm, input logic [7:0] wa,
                       input logic [63:0] wd, input bit wdn, input bit re,
                       input bit rm, input logic [7:0] ra, input bit rdn);
      wr_en = we; wr_mode = wm; wr_addr = wa; wr_data = wd; wr_done = wdn;
      rd_en = re; rd_mode = rm; rd_addr = ra; rd_done = rdn;
      @(posedge clk);
      model_edge(we, wm, wa, wd, wdn, re, rm, ra, rdn);
      #1;
      check_flags();
   endtask

   task automatic drive_idle();
      wr_en = 0; wr_mode = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
      rd_en = 0; rd_mode = 0; rd_addr = '0; rd_done = 0;
   endtask

   // Asynchronous reset asserted mid-cycle; flags must clear before the next edge.
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_flags();
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      check("reset_rd_data", rd_data, 64'd0);
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_flags();
   endtask

   logic [63:0] last_d = '0;
   logic [63:0] last_m = '1;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n !== 1'b1) begin
         check("rst_rd_valid", 64'(rd_valid), 64'd0);
         check("rst_rd_data", rd_data, 64'd0);
         last_d = '0;
         last_m = '1;
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_valid", 64'(rd_valid), 64'd1);
         check("rd_data", rd_data & e.mask, e.data & e.mask);
         last_d = e.data;
         last_m = e.mask;
      end else begin
         check("rd_idle_valid", 64'(rd_valid), 64'd0);
         check("rd_hold", rd_data & last_m, last_d & last_m);
      end
   end

   initial begin
      bit          we, wm, wdn, re, rm, rdn;
      logic [7:0]  wa, ra;
      logic [63:0] wd;
      drive_idle();
      model_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_flags();
      check("init_rd_valid", 64'(rd_valid), 64'd0);
      check("init_rd_data", rd_data, 64'd0);

      // Directed walk through fill, swap, stall, concurrent handshakes.
      step(1, 0, 8'd23, 64'hFF, 0, 0, 0, 8'd0, 0);
      step(1, 1, 8'd7, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 8'd0, 0);
      step(0, 0, 8'd0, 64'd0, 1, 0, 0, 8'd0, 0);
      step(1, 1, 8'd3, 64'h1111_2222_3333_4444, 0, 1, 0, 8'd23, 0);
      step(1, 0, 8'd100, 64'h5A, 0, 1, 1, 8'd7, 0);
      step(0, 0, 8'd0, 64'd0, 1, 1, 0, 8'd57, 0);
      step(1, 1, 8'd3, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 1, 8'd7, 0);
      step(1, 0, 8'd100, 64'hEE, 0, 0, 0, 8'd0, 1);
      step(1, 1, 8'd2, 64'hCAFE_F00D_0BAD_BEEF, 0, 1, 1, 8'd3, 0);
      step(0, 0, 8'd0, 64'd0, 1, 1, 0, 8'd100, 1);
      step(0, 0, 8'd0, 64'd0, 0, 1, 1, 8'd3, 1);
      step(0, 0, 8'd0, 64'd0, 0, 1, 1, 8'd2, 0);
      step(1, 1, 8'd9, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1, 0, 8'd4, 0);
      mid_reset();

      // Randomised traffic with occasional handshakes and resets.
      for (int n = 0; n < 2000; n++) begin
         we  = ($urandom_range(0, 9) < 7);
         wm  = ($urandom_range(0, 9) < 6);
         wa  = 8'($urandom);
         wd  = {$urandom, $urandom};
         wdn = ($urandom_range(0, 19) == 0);
         re  = ($urandom_range(0, 9) < 6);
         rm  = $urandom_range(0, 1) == 1;
         ra  = 8'($urandom);
         rdn = ($urandom_range(0, 19) == 0);
         step(we, wm, wa, wd, wdn, re, rm, ra, rdn);
         if ($urandom_range(0, 499) == 0) mid_reset();
      end

      drive_idle();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
